// File: rtl/dsp_seq_pkg.sv
// Shared types and constants for the DSP48E1 MAC sequencer.
//   mode_t   : command operation select
//   state_t  : sequencer FSM states
//   beat_t   : one delay-line entry {vld, first, mode}
//   opm_encode() : maps a beat emerging at the P stage to its OPMODE
package dsp_seq_pkg;

    typedef enum logic [1:0] {
        MODE_MAC = 2'd0,
        MODE_AB  = 2'd1,
        MODE_CLR = 2'd2,
        MODE_RSV = 2'd3
    } mode_t;

    // OPMODE layout: [1:0] X sel, [3:2] Y sel, [6:4] Z sel
    localparam logic [6:0] OPM_MAC_FIRST = 7'h05;  // X=M, Y=M, Z=0
    localparam logic [6:0] OPM_MAC_ACC   = 7'h25;  // X=M, Y=M, Z=P
    localparam logic [6:0] OPM_AB_FIRST  = 7'h03;  // X=A:B, Y=0, Z=0
    localparam logic [6:0] OPM_AB_ACC    = 7'h23;  // X=A:B, Y=0, Z=P
    localparam logic [6:0] OPM_IDLE      = 7'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic  vld;
        logic  first;
        mode_t mode;
    } beat_t;

    // Bubbles and clear beats both produce all-zero selects; ce_p alone
    // distinguishes a clear (P <= 0) from an idle stage.
    function automatic logic [6:0] opm_encode(input beat_t b);
        logic [6:0] r;
        r = OPM_IDLE;
        if (b.vld) begin
            case (b.mode)
                MODE_MAC: r = b.first ? OPM_MAC_FIRST : OPM_MAC_ACC;
                MODE_AB:  r = b.first ? OPM_AB_FIRST  : OPM_AB_ACC;
                default:  r = OPM_IDLE;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// Command and operand handshake bundle between the operand source and the
// MAC sequencer.
//   start, cmd_mode, cmd_len : command strobe and fields (sampled in IDLE)
//   in_valid / in_ready      : operand beat handshake on the DSP A/B inputs
//   master : command/operand source     slave : sequencer
interface dsp_mac_sequencer_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [1:0]       cmd_mode;
    logic [LEN_W-1:0] cmd_len;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output start, cmd_mode, cmd_len, in_valid,
        input  in_ready
    );

    modport slave (
        input  start, cmd_mode, cmd_len, in_valid,
        output in_ready
    );
endinterface

// File: rtl/dsp_seq_delay.sv
// Delay line that time-aligns accepted beats to the DSP P stage.
//   clk      : clock
//   clear    : synchronous clear of every stage
//   in_beat  : beat pushed this cycle (vld=0 is a bubble)
//   out_beat : beat at the P stage (STAGES cycles after push)
//   empty    : no valid beat on the input or in any stage
// STAGES=0 degenerates to a wire, so the P-stage outputs follow acceptance
// combinationally.
module dsp_seq_delay
    import dsp_seq_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic  clk,
    input  logic  clear,
    input  beat_t in_beat,
    output beat_t out_beat,
    output logic  empty
);

    generate
        if (STAGES == 0) begin : g_pass
            assign out_beat = in_beat;
            assign empty    = ~in_beat.vld;
        end else begin : g_pipe
            beat_t pipe [STAGES];

            always_ff @(posedge clk) begin
                if (clear) begin
                    for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= in_beat;
                    for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
                end
            end

            always_comb begin
                empty = ~in_beat.vld;
                for (int i = 0; i < STAGES; i++) begin
                    if (pipe[i].vld) empty = 1'b0;
                end
            end

            assign out_beat = pipe[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Sequencer for multi-cycle DSP48E1 accumulate operations.
// Takes a command (mode, length), pulls operand beats over valid/ready and
// drives OPMODE / ce_p aligned to the P stage through a delay line.
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : start/cmd_mode/cmd_len command, in_valid/in_ready operands
//   busy         : command in progress (FEED, or DRAIN before completion)
//   opmode, ce_p : DSP OPMODE and P-register enable at the P stage
//   result_valid : one-cycle pulse, P holds the final result
//   err          : one-cycle pulse, illegal command rejected
// PIPE_LAT is the operand-to-P-update latency, legal range 1..8.
module dsp_mac_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int LEN_W    = 8,
    parameter int PIPE_LAT = 3
) (
    input  logic                clk,
    input  logic                rst,
    dsp_mac_sequencer_if.slave  bus,
    output logic                busy,
    output logic [6:0]          opmode,
    output logic                ce_p,
    output logic                result_valid,
    output logic                err
);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    mode_t            mode_q, mode_d;
    logic             first_q, first_d;
    logic             err_q, err_d;
    logic             in_ready;
    beat_t            push;
    beat_t            p_beat;
    logic             pipe_empty;
    mode_t            cmd_mode;

    assign cmd_mode     = mode_t'(bus.cmd_mode);
    assign bus.in_ready = in_ready;

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        mode_d       = mode_q;
        first_d      = first_q;
        err_d        = 1'b0;
        push         = '0;
        in_ready     = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (cmd_mode == MODE_CLR) begin
                        // Clear needs no operands: its single beat enters
                        // the delay line in the start cycle itself.
                        push    = '{vld: 1'b1, first: 1'b1, mode: MODE_CLR};
                        mode_d  = MODE_CLR;
                        state_d = ST_DRAIN;
                    end else if (cmd_mode == MODE_RSV || bus.cmd_len == '0) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d  = cmd_mode;
                        rem_d   = bus.cmd_len;
                        first_d = 1'b1;
                        state_d = ST_FEED;
                    end
                end
            end

            ST_FEED: begin
                busy     = 1'b1;
                in_ready = (rem_q != '0);
                if (in_ready && bus.in_valid) begin
                    push    = '{vld: 1'b1, first: first_q, mode: mode_q};
                    first_d = 1'b0;
                    rem_d   = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) state_d = ST_DRAIN;
                end else if (rem_q == '0) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                // Completion is reported in the cycle after the last beat
                // left the P stage, so busy drops together with the pulse.
                if (pipe_empty) begin
                    result_valid = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    busy = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            mode_q  <= MODE_MAC;
            first_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            first_q <= first_d;
            err_q   <= err_d;
        end
    end

    dsp_seq_delay #(
        .STAGES (PIPE_LAT - 1)
    ) u_delay (
        .clk      (clk),
        .clear    (rst),
        .in_beat  (push),
        .out_beat (p_beat),
        .empty    (pipe_empty)
    );

    assign opmode = opm_encode(p_beat);
    assign ce_p   = p_beat.vld;
    assign err    = err_q;

    // M product needs both X and Y; P feedback only ever enters through Z.
    a_mult_xy: assert property (@(posedge clk) disable iff (rst)
        (opmode[1:0] == 2'b01) |-> (opmode[3:2] == 2'b01));
    a_no_x_p: assert property (@(posedge clk) disable iff (rst)
        opmode[1:0] != 2'b10);
    a_rem_nz: assert property (@(posedge clk) disable iff (rst)
        (state_q == ST_FEED) |-> (rem_q != '0));

endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
- Controller that sequences the DSP48E1 datapath for multi-cycle accumulate operations.
- Accepts a command (mode, length) and pulls operands with a valid/ready handshake.
- Drives OPMODE (X/Y/Z mux selects) and the P-register clock enable, time-aligned to the P stage through an internal delay line.
- Flags result completion.
- Sits between the command/operand source and the DSP slice (x_mux, y_mux, z_mux, ALU, P register).

Parameters:
- LEN_W, 8, width of the command length field (max 2^LEN_W-1 operands).
- PIPE_LAT, 3, cycles from operand acceptance to the P-register update for that operand (A/B reg, M reg, P reg); legal range 1..8.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- cmd_mode  in  2  operation select: 0 = MAC (M accumulate), 1 = A:B accumulate, 2 = clear P, 3 = reserved.
- cmd_len  in  LEN_W  number of operand beats for modes 0/1; ignored for mode 2.
- in_valid  in  1  operand source has a beat on the DSP A/B inputs.
- in_ready  out  1  sequencer consumes the beat this cycle.
- busy  out  1  command in progress (FEED or DRAIN).
- opmode  out  7  DSP OPMODE: [1:0] x_mux sel, [3:2] y_mux sel, [6:4] z_mux sel; aligned to the P stage.
- ce_p  out  1  P-register clock enable; aligned to the P stage.
- result_valid  out  1  one-cycle pulse: P holds the final result.
- err  out  1  one-cycle pulse: illegal command rejected.

Behaviour:
- Reset values: in_ready=0, busy=0, opmode=7'h00, ce_p=0, result_valid=0, err=0. Delay line, counter and mode register are cleared; state = IDLE.
- Reset mid-operation aborts immediately: no result_valid, and no ce_p on later cycles. rst wins over start in the same cycle.
- States: IDLE, FEED, DRAIN.
- IDLE:
  - start with mode 0/1 and cmd_len>0 latches mode and length, and goes to FEED next cycle.
  - start with mode 2 goes to DRAIN, injecting one clear beat.
  - start with mode 3, or mode 0/1 with cmd_len=0, pulses err the next cycle and stays in IDLE.
- FEED:
  - in_ready = 1 while remaining>0. A beat is accepted when in_valid & in_ready.
  - Each accepted beat decrements remaining and pushes {first_flag, mode} into the delay line.
  - No push when in_valid is low (stall); stalls are unbounded.
  - When the last beat is accepted, in_ready drops the next cycle and the state goes to DRAIN.
- DRAIN: waits until the delay line is empty, then pulses result_valid and returns to IDLE. busy is high in FEED and DRAIN, low in the result_valid cycle.
- Delay line: PIPE_LAT-1 stages of {valid, first, mode}. A beat accepted in cycle t drives opmode/ce_p in cycle t+PIPE_LAT-1; P is updated at the end of that cycle.
- result_valid is asserted in cycle t_last+PIPE_LAT.
- With PIPE_LAT=1 the outputs are combinational from acceptance.
- OPMODE encoding per emerging stage:
  - MAC first beat: 7'h05 (X=M, Y=M, Z=0).
  - MAC later beats: 7'h25 (Z=P).
  - A:B first beat: 7'h03 (X=A:B, Y=0, Z=0).
  - A:B later beats: 7'h23.
  - Clear beat: 7'h00.
  - Bubble or idle: 7'h00 with ce_p=0.
- ce_p = 1 exactly on stages carrying a valid beat.
- Invariant, checked by assertion: x_sel==01 implies y_sel==01 (the M product uses both muxes). x_sel is never 10 (P feedback goes via Z only).
- start while busy is ignored; there is no queueing.
- remaining counter never wraps below 0.

Decomposition:
- Package dsp_seq_pkg holds:
  - mode constants: MODE_MAC=2'd0, MODE_AB=2'd1, MODE_CLR=2'd2, MODE_RSV=2'd3.
  - OPMODE constants: OPM_MAC_FIRST=7'h05, OPM_MAC_ACC=7'h25, OPM_AB_FIRST=7'h03, OPM_AB_ACC=7'h23, OPM_IDLE=7'h00.
  - the state enum.
- One sub-module, dsp_seq_delay: a parameterised PIPE_LAT-1 stage shift register of {valid, first, mode}, with synchronous clear.

Test Plan:
- MAC, len=4, in_valid held 1, PIPE_LAT=3:
  - in_ready high for 4 cycles.
  - opmode sequence 05,25,25,25 with ce_p=1, starting 2 cycles after the first acceptance.
  - result_valid 3 cycles after the 4th acceptance.
- A:B, len=3, in_valid pattern 1,0,0,1,1:
  - ce_p pattern 1,0,0,1,1 with opmode 03,00,00,23,23.
  - A single result_valid pulse.
- Clear (mode 2, cmd_len=17):
  - No in_ready.
  - One opmode=00 with ce_p=1, then result_valid.
- Illegal commands:
  - mode 3 -> err pulse, busy stays 0.
  - mode 0 with len=0 -> err pulse.
  - In both cases opmode stays 00 and ce_p stays 0.
- Reset mid-FEED:
  - MAC len=8, rst asserted after 3 beats.
  - All outputs at reset values the next cycle.
  - No further ce_p, no result_valid.
  - A new MAC len=2 then completes normally with opmode 05,25.
- start pulsed while busy, and start with rst in the same cycle:
  - Both ignored; the command in progress completes unchanged.
  - The OPMODE invariant assertion holds over 2000 random commands.
